// File: rtl/mul_seq_ctrl_if.sv
// Request/response channel between the execute stage and the multiply controller.
// The execute stage is the master; the controller is the slave.
interface mul_seq_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic             req_word;
  logic [63:0]      req_a;
  logic [63:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_funct3, req_word, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_funct3, req_word, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequences RV64 M-extension multiplies onto a shared unsigned 64x64 multiplier:
// sign-magnitude conversion, launch/wait, sign fix-up, half select and tagged response.
module mul_seq_ctrl #(
  parameter int TAG_W        = 5,
  parameter int START_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus,
  input  logic          flush,
  output logic          mul_start,
  output logic [63:0]   mul_a,
  output logic [63:0]   mul_b,
  input  logic [127:0]  mul_s,
  input  logic          mul_done,
  output logic          busy
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] FIX    = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;
  localparam int         CNT_W  = $clog2(START_CYCLES + 1);

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [63:0]      mul_a_reg;
  logic [63:0]      mul_b_reg;
  logic             neg_reg;
  logic             hi_reg;
  logic             word_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [127:0]     prod_reg;
  logic [63:0]      data_reg;

  // Undefined funct3 values (1xx) collapse onto MUL before any decode.
  logic [2:0]   op;
  logic         word;
  logic         a_signed;
  logic         b_signed;
  logic [63:0]  a_ext;
  logic [63:0]  b_ext;
  logic         a_neg;
  logic         b_neg;
  logic [63:0]  a_mag;
  logic [63:0]  b_mag;
  logic [127:0] prod_fix;
  logic [63:0]  result;

  assign op       = bus.req_funct3[2] ? 3'b000 : bus.req_funct3;
  assign word     = bus.req_word && (op == 3'b000);
  assign a_signed = word || (op == 3'b001) || (op == 3'b010);
  assign b_signed = word || (op == 3'b001);
  assign a_ext    = word ? {{32{bus.req_a[31]}}, bus.req_a[31:0]} : bus.req_a;
  assign b_ext    = word ? {{32{bus.req_b[31]}}, bus.req_b[31:0]} : bus.req_b;
  assign a_neg    = a_signed && a_ext[63];
  assign b_neg    = b_signed && b_ext[63];
  assign a_mag    = a_neg ? (~a_ext + 64'd1) : a_ext;
  assign b_mag    = b_neg ? (~b_ext + 64'd1) : b_ext;

  assign prod_fix = neg_reg ? (~prod_reg + 128'd1) : prod_reg;
  assign result   = word_reg ? {{32{prod_fix[31]}}, prod_fix[31:0]}
                  : hi_reg   ? prod_fix[127:64]
                  :            prod_fix[63:0];

  // A drained launch still owes its remaining start cycles to the multiplier.
  assign mul_start      = (state_reg == LAUNCH) || ((state_reg == DRAIN) && (cnt_reg != '0));
  assign mul_a          = mul_a_reg;
  assign mul_b          = mul_b_reg;
  assign busy           = (state_reg != IDLE);
  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_data  = data_reg;
  assign bus.resp_tag   = tag_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      neg_reg   <= 1'b0;
      hi_reg    <= 1'b0;
      word_reg  <= 1'b0;
      tag_reg   <= '0;
      prod_reg  <= '0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            mul_a_reg <= a_mag;
            mul_b_reg <= b_mag;
            neg_reg   <= a_neg ^ b_neg;
            hi_reg    <= (op != 3'b000);
            word_reg  <= word;
            tag_reg   <= bus.req_tag;
            cnt_reg   <= CNT_W'(START_CYCLES);
            if ((a_ext == 64'd0) || (b_ext == 64'd0)) begin
              data_reg  <= '0;
              state_reg <= RESP;
            end else begin
              state_reg <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (flush) begin
            state_reg <= DRAIN;
          end else if (cnt_reg == CNT_W'(1)) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // A done coinciding with flush already retires the product.
          if (flush) begin
            state_reg <= mul_done ? IDLE : DRAIN;
          end else if (mul_done) begin
            prod_reg  <= mul_s;
            state_reg <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            data_reg  <= result;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (flush || bus.resp_ready) begin
            state_reg <= IDLE;
          end
        end
        DRAIN: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (mul_done) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomised bench for mul_seq_ctrl: a behavioural multiplier drives done, and a
// signed/unsigned 128-bit arithmetic reference predicts every tagged response.
module tb_mul_seq_ctrl;
  localparam int TAG_W        = 5;
  localparam int START_CYCLES = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         mul_start;
  logic [63:0]  mul_a;
  logic [63:0]  mul_b;
  logic [127:0] mul_s = '0;
  logic         mul_done = 1'b0;
  logic         busy;

  mul_seq_ctrl_if #(.TAG_W(TAG_W)) bus ();

  mul_seq_ctrl #(.TAG_W(TAG_W), .START_CYCLES(START_CYCLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flush    (flush),
    .mul_start(mul_start),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_s    (mul_s),
    .mul_done (mul_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    bit               zero;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   force_delay = -1;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result defined directly as the wrapped product of the extended operands.
  function automatic logic [63:0] ref_mul(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [2:0]   op;
    logic [127:0] ea;
    logic [127:0] eb;
    logic [127:0] p;
    op = f3[2] ? 3'b000 : f3;
    if (w && op == 3'b000) begin
      ea = {{96{a[31]}}, a[31:0]};
      eb = {{96{b[31]}}, b[31:0]};
      p  = ea * eb;
      return {{32{p[31]}}, p[31:0]};
    end
    ea = (op == 3'b001 || op == 3'b010) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (op == 3'b001) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return (op == 3'b000) ? p[63:0] : p[127:64];
  endfunction

  function automatic bit ref_zero(input logic [2:0] f3, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
    if (w && !f3[1] && !f3[0] || (w && f3[2]))
      return (a[31:0] == 32'd0) || (b[31:0] == 32'd0);
    return (a == 64'd0) || (b == 64'd0);
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'd1;
      4:       return {32'd0, $urandom};
      5:       return {$urandom, 32'd0};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Behavioural multiplier: done pulses some cycles after start falls.
  initial begin
    int cd;
    bit pend;
    bit start_q;
    cd = 0;
    pend = 0;
    start_q = 0;
    forever begin
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
        start_q = 0;
      end else begin
        if (start_q && !mul_start) begin
          pend = 1;
          cd = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
        end
        start_q = mul_start;
        if (pend) begin
          if (cd == 0) begin
            mul_done = 1'b1;
            mul_s = {64'd0, mul_a} * {64'd0, mul_b};
            pend = 0;
          end else begin
            cd--;
          end
        end
      end
    end
  end

  // Scoreboard bookkeeping on the handshakes seen at each active edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush && busy) sb.delete();
      if (bus.resp_valid && bus.resp_ready && sb.size() > 0) void'(sb.pop_front());
      if (bus.req_valid && bus.req_ready) begin
        exp_t e;
        e.data = ref_mul(bus.req_funct3, bus.req_word, bus.req_a, bus.req_b);
        e.tag  = bus.req_tag;
        e.zero = ref_zero(bus.req_funct3, bus.req_word, bus.req_a, bus.req_b);
        e.acc  = cyc;
        sb.push_back(e);
        last_acc = cyc;
      end
    end
  end

  // Per-cycle compare against the scoreboard and the protocol rules.
  initial begin
    bit               pv_valid;
    bit               pv_ready;
    bit               pv_flush;
    bit               pv_hs;
    bit               pv_start;
    logic [63:0]      pv_data;
    logic [TAG_W-1:0] pv_tag;
    int               run;
    int               last_done;
    pv_valid = 0; pv_ready = 0; pv_flush = 0; pv_hs = 0; pv_start = 0;
    pv_data = '0; pv_tag = '0; run = 0; last_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pv_valid = 0; pv_hs = 0; pv_start = 0; run = 0;
        continue;
      end
      check(bus.req_ready == !busy, "ready_vs_busy", 128'(bus.req_ready), 128'(!busy));
      check(!(mul_start && mul_done), "done_during_start", 128'(mul_done), 128'(0));
      if (mul_done) last_done = cyc;
      if (mul_start) begin
        if (!pv_start) begin
          check(cyc - last_acc == 1, "start_after_accept", 128'(cyc - last_acc), 128'(1));
          check(sb.size() > 0, "start_without_op", 128'(sb.size()), 128'(1));
          if (sb.size() > 0) check(!sb[0].zero, "start_on_zero", 128'(sb[0].zero), 128'(0));
        end
        run++;
      end else if (pv_start) begin
        check(run == START_CYCLES, "start_len", 128'(run), 128'(START_CYCLES));
        run = 0;
      end
      if (bus.resp_valid) begin
        check(!bus.req_ready, "ready_in_resp", 128'(bus.req_ready), 128'(0));
        check(sb.size() > 0, "spurious_resp", 128'(sb.size()), 128'(1));
        if (sb.size() > 0) begin
          check(bus.resp_data == sb[0].data, "resp_data", 128'(bus.resp_data), 128'(sb[0].data));
          check(bus.resp_tag == sb[0].tag, "resp_tag", 128'(bus.resp_tag), 128'(sb[0].tag));
          if (!pv_valid) begin
            if (sb[0].zero)
              check(cyc - sb[0].acc == 1, "zero_latency", 128'(cyc - sb[0].acc), 128'(1));
            else
              check(cyc - last_done == 2, "done_to_resp", 128'(cyc - last_done), 128'(2));
          end
        end
      end
      if (pv_valid && !pv_ready && !pv_flush) begin
        check(bus.resp_valid, "hold_valid", 128'(bus.resp_valid), 128'(1));
        check(bus.resp_data == pv_data, "hold_data", 128'(bus.resp_data), 128'(pv_data));
        check(bus.resp_tag == pv_tag, "hold_tag", 128'(bus.resp_tag), 128'(pv_tag));
      end
      if (pv_hs) check(bus.req_ready, "ready_after_resp", 128'(bus.req_ready), 128'(1));
      pv_valid = bus.resp_valid;
      pv_ready = bus.resp_ready;
      pv_flush = flush;
      pv_data  = bus.resp_data;
      pv_tag   = bus.resp_tag;
      pv_hs    = bus.resp_valid && bus.resp_ready;
      pv_start = mul_start;
    end
  end

  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [TAG_W-1:0] tag, input bit with_flush);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    while (!bus.req_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(bus.req_ready, "req_ready_timeout", 128'(bus.req_ready), 128'(1));
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_word   = w;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_tag    = tag;
    flush          = with_flush;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic collect(input int hold);
    int t;
    t = 0;
    while (!bus.resp_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(bus.resp_valid, "resp_timeout", 128'(bus.resp_valid), 128'(1));
    bus.resp_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic wait_drain();
    bit seen;
    int t;
    seen = 0;
    t = 0;
    while (!seen && t < 50) begin
      @(negedge clk);
      t++;
      check(!bus.resp_valid, "flush_no_resp", 128'(bus.resp_valid), 128'(0));
      if (mul_done) seen = 1;
      else check(busy, "busy_in_drain", 128'(busy), 128'(1));
    end
    check(seen, "drain_done_timeout", 128'(seen), 128'(1));
    @(negedge clk);
    check(!busy && bus.req_ready, "idle_after_drain", 128'(bus.req_ready), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_funct3 = 0; bus.req_word = 0;
    bus.req_a = 0; bus.req_b = 0; bus.req_tag = 0; bus.resp_ready = 0;

    // Hand-computed values pinning the reference model.
    check(ref_mul(3'b000, 1'b0, 64'd3, 64'd5) == 64'h0F, "pin_mul", 128'(ref_mul(3'b000, 1'b0, 64'd3, 64'd5)), 128'h0F);
    check(ref_mul(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000) == 64'h4000_0000_0000_0000,
          "pin_mulh_min", 128'(ref_mul(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000)), 128'h4000_0000_0000_0000);
    check(ref_mul(3'b001, 1'b0, '1, '1) == 64'd0, "pin_mulh_m1", 128'(ref_mul(3'b001, 1'b0, '1, '1)), 128'd0);
    check(ref_mul(3'b011, 1'b0, '1, '1) == 64'hFFFF_FFFF_FFFF_FFFE, "pin_mulhu",
          128'(ref_mul(3'b011, 1'b0, '1, '1)), 128'hFFFF_FFFF_FFFF_FFFE);
    check(ref_mul(3'b010, 1'b0, '1, 64'd2) == 64'hFFFF_FFFF_FFFF_FFFF, "pin_mulhsu",
          128'(ref_mul(3'b010, 1'b0, '1, 64'd2)), 128'hFFFF_FFFF_FFFF_FFFF);
    check(ref_mul(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2) == 64'hFFFF_FFFF_FFFF_FFFE, "pin_mulw",
          128'(ref_mul(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2)), 128'hFFFF_FFFF_FFFF_FFFE);

    repeat (3) @(negedge clk);
    check(bus.req_ready == 1'b1, "rst_req_ready", 128'(bus.req_ready), 128'(1));
    check(bus.resp_valid == 1'b0, "rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    check(mul_start == 1'b0, "rst_mul_start", 128'(mul_start), 128'(0));
    check(busy == 1'b0, "rst_busy", 128'(busy), 128'(0));
    check(bus.resp_data == 64'd0 && bus.resp_tag == '0, "rst_resp", 128'(bus.resp_data), 128'(0));
    check(mul_a == 64'd0 && mul_b == 64'd0, "rst_mul_ab", {mul_a, mul_b}, 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(3'b000, 1'b0, 64'd3, 64'd5, 5'h11, 0);                     collect(0);
    issue(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'h02, 0); collect(1);
    issue(3'b001, 1'b0, '1, '1, 5'h03, 0);                           collect(0);
    issue(3'b011, 1'b0, '1, '1, 5'h04, 0);                           collect(0);
    issue(3'b010, 1'b0, '1, 64'd2, 5'h05, 0);                        collect(0);
    issue(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'h06, 0);             collect(0);
    issue(3'b000, 1'b0, 64'h1234_5678, 64'd0, 5'h07, 0);             collect(0);
    issue(3'b110, 1'b0, 64'd7, 64'd6, 5'h08, 0);                     collect(0);
    issue(3'b011, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0003, 5'h1F, 0); collect(10);

    // Flush while waiting on the multiplier: drain, then a fresh request.
    force_delay = 8;
    issue(3'b000, 1'b0, 64'd7, 64'd9, 5'h03, 0);
    repeat (START_CYCLES + 1) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_drain();
    force_delay = -1;
    issue(3'b001, 1'b0, -64'sd12345, 64'd1000, 5'h09, 0);            collect(0);

    // Flush on the first launch cycle still completes the start pulse.
    force_delay = 3;
    issue(3'b000, 1'b0, 64'd5, 64'd5, 5'h0A, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_drain();
    force_delay = -1;

    // Flush while the response is pending drops it.
    issue(3'b000, 1'b0, 64'd0, 64'd9, 5'h0B, 0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check(!bus.resp_valid && !busy, "flush_in_resp", 128'(bus.resp_valid), 128'(0));

    // Flush arriving with a request in IDLE does not cancel it.
    issue(3'b000, 1'b0, 64'd11, 64'd12, 5'h0C, 1'b1);                collect(0);

    for (int i = 0; i < 100; i++) begin
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      f3 = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 3) == 0);
      a  = pick();
      b  = pick();
      issue(f3, w, a, b, TAG_W'($urandom), 0);
      collect(int'($urandom_range(0, 3)));
    end

    // Reset in the middle of an operation returns to idle at once.
    force_delay = 6;
    issue(3'b000, 1'b0, 64'd11, 64'd13, 5'h07, 0);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check(!busy && bus.req_ready, "midop_rst_idle", 128'(busy), 128'(0));
    check(!bus.resp_valid && !mul_start, "midop_rst_outs", 128'(bus.resp_valid), 128'(0));
    check(bus.resp_data == 64'd0, "midop_rst_data", 128'(bus.resp_data), 128'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_delay = -1;
    issue(3'b000, 1'b0, 64'd11, 64'd13, 5'h0D, 0);                   collect(0);

    repeat (5) @(negedge clk);
    check(sb.size() == 0, "all_responses", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencing controller between the RV64 execute stage and the shared karatsuba_64b unsigned multiplier.
- Accepts M-extension multiply requests (MUL/MULH/MULHSU/MULHU/MULW) over a valid/ready handshake.
- Converts signed operands to magnitudes, launches the multiplier and waits for its done.
- Applies sign correction, selects the result half, sign-extends word results, and returns the result with its destination tag.

Parameters:
- TAG_W, 5, width of the destination-register tag carried through unchanged.
- START_CYCLES, 2, cycles mul_start is held high per launch (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept request
- req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; others rejected as MUL
- req_word  in  1  MULW; valid only with funct3=000
- req_a  in  64  rs1 operand
- req_b  in  64  rs2 operand
- req_tag  in  TAG_W  destination tag
- flush  in  1  discard in-flight operation
- mul_start  out  1  to karatsuba_64b start
- mul_a  out  64  unsigned magnitude of a
- mul_b  out  64  unsigned magnitude of b
- mul_s  in  128  karatsuba_64b product
- mul_done  in  1  karatsuba_64b done
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  64  result
- resp_tag  out  TAG_W  tag of result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - req_ready=1, resp_valid=0, mul_start=0, busy=0.
  - resp_data=0, resp_tag=0, mul_a=0, mul_b=0.
- States: IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN.
- IDLE: req_ready=1. On req_valid, latch the operation:
  - a_signed = funct3 in {001,010}; b_signed = funct3==001.
  - MULW: a and b are sign-extended from bits [31:0] and treated as signed.
  - Latch magnitudes |a|, |b|, neg = sign_a XOR sign_b (using signed flags only), funct3, word, tag.
  - Zero fast path: if either operand is 0, go directly to RESP with resp_data=0 (no launch). Otherwise go to LAUNCH.
  - Magnitude of 0x8000_0000_0000_0000 is 0x8000_0000_0000_0000 as an unsigned value.
- LAUNCH: mul_start=1 for START_CYCLES cycles; mul_a/mul_b are stable from LAUNCH entry until leaving WAIT. Then go to WAIT.
- WAIT: mul_done is sampled only here, never while mul_start=1. On mul_done=1, capture mul_s and go to FIX.
- FIX (1 cycle): p = neg ? (~mul_s + 1) : mul_s, 128-bit wrap. Select the result:
  - MUL: p[63:0].
  - MULH/MULHSU/MULHU: p[127:64].
  - MULW: sign-extend p[31:0] to 64 bits.
  - Go to RESP.
- RESP: resp_valid=1; resp_data and resp_tag are held stable until resp_ready=1. On the acceptance cycle go to IDLE; the next request can be accepted on the following cycle.
- Latency: req accept -> resp_valid = 1 + START_CYCLES + (WAIT cycles up to and including done) + 1. Zero fast path gives resp_valid on the cycle after accept.
- req_ready=0 in every state except IDLE. No request is buffered while busy.
- flush:
  - In IDLE: no effect.
  - In LAUNCH or WAIT: go to DRAIN. The remaining START_CYCLES are completed, then the controller waits for mul_done, discards the product, and returns to IDLE without resp_valid.
  - In FIX or RESP: drop the result; resp_valid falls the next cycle; go to IDLE.
  - Flush together with req_valid in IDLE: the request is accepted. Flush applies only to an already-accepted operation.
- Reset mid-operation forces IDLE immediately. The controller does not wait for the multiplier; the multiplier is reset by the same rst_n.
- Undefined funct3 (1xx) executes as MUL.

Test Plan:
- MUL a=3, b=5 -> resp_data=0x000000000000000F; tag echoed; mul_start high exactly 2 cycles.
- MULH a=b=0x8000000000000000 -> 0x4000000000000000. MULH a=b=0xFFFFFFFFFFFFFFFF -> 0x0000000000000000.
- MULHU a=b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE. MULHSU a=0xFFFFFFFFFFFFFFFF, b=2 -> 0xFFFFFFFFFFFFFFFF.
- MULW a=0x000000007FFFFFFF, b=2 -> 0xFFFFFFFFFFFFFFFE. MUL with b=0 -> 0 one cycle after accept, mul_start never asserted.
- Backpressure: hold resp_ready=0 for 10 cycles -> resp_valid, resp_data and resp_tag stable, req_ready=0 throughout.
- flush in WAIT -> no resp_valid, busy stays high until mul_done, then req_ready=1. Next request returns the correct product with the new tag. Plus 100 random requests checked against a reference model.
